alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 116 +++++++++++
 tb/tb_alu_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer that drives an external combinational ALU, optionally iterating
// the same operation cmd_count times. Iteration is enabled by defining ALU_SEQ_ITER_EN.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             flags_load,
    input  logic [3:0]       flags_load_val,
    output logic [WIDTH-1:0] alu_operand1,
    output logic [WIDTH-1:0] alu_operand2,
    output logic [2:0]       alu_operation,
    output logic [3:0]       alu_flags_in,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic [3:0]       flags
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [2:0]       op_reg;
    logic [3:0]       ccr_reg;
    logic             rsp_valid_reg;

`ifdef ALU_SEQ_ITER_EN
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    logic [CNT_W-1:0] rem_reg;
`else
    // Count is irrelevant when every command is a single iteration.
    logic unused_count;
    assign unused_count = ^cmd_count;
`endif

    // A pending flag restore takes priority over a command in the same cycle.
    assign cmd_ready     = (state_reg == IDLE) && !flags_load && !rst;

    assign alu_operand1  = acc_reg;
    assign alu_operand2  = opb_reg;
    assign alu_operation = op_reg;
    assign alu_flags_in  = ccr_reg;

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_result    = acc_reg;
    assign rsp_flags     = ccr_reg;
    assign flags         = ccr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            opb_reg       <= '0;
            op_reg        <= '0;
            ccr_reg       <= '0;
            rsp_valid_reg <= 1'b0;
`ifdef ALU_SEQ_ITER_EN
            rem_reg       <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (flags_load) begin
                        ccr_reg <= flags_load_val;
                    end else if (cmd_valid) begin
                        acc_reg   <= cmd_a;
                        opb_reg   <= cmd_b;
                        op_reg    <= cmd_op;
`ifdef ALU_SEQ_ITER_EN
                        rem_reg   <= (cmd_count == '0) ? ONE : cmd_count;
`endif
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    // Flags feed back through ccr so each iteration sees the previous carry.
                    acc_reg <= alu_result;
                    ccr_reg <= alu_flags_out;
`ifdef ALU_SEQ_ITER_EN
                    rem_reg <= rem_reg - ONE;
                    if (rem_reg == ONE) begin
                        state_reg     <= DONE;
                        rsp_valid_reg <= 1'b1;
                    end
`else
                    state_reg     <= DONE;
                    rsp_valid_reg <= 1'b1;
`endif
                end
                DONE: begin
                    if (rsp_ready) begin
                        state_reg     <= IDLE;
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    rsp_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: directed vector table, multi-cycle corner
// sequences and randomized commands checked against an iterate-the-ALU reference model.
module tb_alu_sequencer;

    localparam int W = 16;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [C-1:0] cmd_count = '0;
    logic         flags_load = 1'b0;
    logic [3:0]   flags_load_val = '0;
    logic [W-1:0] alu_operand1;
    logic [W-1:0] alu_operand2;
    logic [2:0]   alu_operation;
    logic [3:0]   alu_flags_in;
    logic [W-1:0] alu_result;
    logic [3:0]   alu_flags_out;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic [3:0]   rsp_flags;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;
    logic [3:0] model_flags = '0;

    alu_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_count(cmd_count),
        .flags_load(flags_load), .flags_load_val(flags_load_val),
        .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_operation(alu_operation), .alu_flags_in(alu_flags_in),
        .alu_result(alu_result), .alu_flags_out(alu_flags_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .flags(flags)
    );

    always #5 clk = ~clk;

    // Bench ALU: 0 add, 1 add-with-carry, 2 sub (carry=borrow), 3 and, 4 or, 5 xor,
    // 6 pass b, 7 shift-left. Logic ops keep carry; bit3 passes through.
    function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op, input logic [3:0] fin);
        logic [W:0]   wide;
        logic [W-1:0] r;
        logic         c;
        wide = '0;
        c = fin[2];
        case (op)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[W-1:0]; c = wide[W]; end
            3'd1: begin wide = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, fin[2]}; r = wide[W-1:0]; c = wide[W]; end
            3'd2: begin r = a - b; c = (a < b); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = b;
            default: begin r = {a[W-2:0], 1'b0}; c = a[W-1]; end
        endcase
        return {fin[3], c, r[W-1], (r == '0), r};
    endfunction

    always_comb {alu_flags_out, alu_result} = alu_f(alu_operand1, alu_operand2, alu_operation, alu_flags_in);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_count(input logic [C-1:0] cnt);
`ifdef ALU_SEQ_ITER_EN
        return (cnt == '0) ? 1 : int'(cnt);
`else
        return 1;
`endif
    endfunction

    // Issue one command, check latency/result/flags, hold backpressure, then release.
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [C-1:0] cnt,
                           input logic [W-1:0] er, input logic [3:0] ef, input int elat,
                           input int hold, input bit noise);
        int lat;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_count = cnt; cmd_valid = 1'b1;
        #1;
        check({tag, ".accept_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            cmd_a = W'($urandom); cmd_b = W'($urandom);
            cmd_op = 3'($urandom); cmd_count = C'($urandom);
            flags_load = noise; flags_load_val = 4'b1011;
            #1;
            check({tag, ".busy_ready"}, 32'(cmd_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(elat));
        check({tag, ".result"}, 32'(rsp_result), 32'(er));
        check({tag, ".rsp_flags"}, 32'(rsp_flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            cmd_a = W'($urandom);
            @(posedge clk); #1;
            check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, ".hold_result"}, 32'(rsp_result), 32'(er));
            check({tag, ".hold_flags"}, 32'(rsp_flags), 32'(ef));
            check({tag, ".hold_ready"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0; cmd_valid = 1'b0; flags_load = 1'b0;
        check({tag, ".released"}, 32'(rsp_valid), 32'd0);
        check({tag, ".flags_after"}, 32'(flags), 32'(ef));
        @(posedge clk); #1;
        check({tag, ".no_extra"}, 32'(rsp_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'(cmd_ready), 32'd1);
        model_flags = ef;
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [C-1:0] cnt;
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [W-1:0] m_acc;
        logic [3:0]   m_f;
        logic [2:0]   r_op;
        logic [W-1:0] r_a, r_b;
        logic [C-1:0] r_cnt;
        logic [3:0]   r_val;
        int           n;

        vecs[0] = '{3'd0, 16'h0ffe, 16'h0001, 4'd1, 16'h0fff, 4'b0000, 1};
        vecs[1] = '{3'd0, 16'hffff, 16'h0001, 4'd1, 16'h0000, 4'b0101, 1};
        vecs[2] = '{3'd1, 16'h0010, 16'h0001, 4'd1, 16'h0012, 4'b0000, 1};
`ifdef ALU_SEQ_ITER_EN
        vecs[3] = '{3'd0, 16'h0003, 16'h0005, 4'd4, 16'h0017, 4'b0000, 4};
`else
        vecs[3] = '{3'd0, 16'h0003, 16'h0005, 4'd4, 16'h0008, 4'b0000, 1};
`endif
        vecs[4] = '{3'd0, 16'h0003, 16'h0005, 4'd0, 16'h0008, 4'b0000, 1};
`ifdef ALU_SEQ_ITER_EN
        vecs[5] = '{3'd1, 16'hfffe, 16'h0001, 4'd3, 16'h0002, 4'b0000, 3};
`else
        vecs[5] = '{3'd1, 16'hfffe, 16'h0001, 4'd3, 16'hffff, 4'b0010, 1};
`endif
        vecs[6] = '{3'd3, 16'hf0f0, 16'h0ff0, 4'd1, 16'h00f0, 4'b0000, 1};
        vecs[7] = '{3'd2, 16'h0001, 16'h0002, 4'd1, 16'hffff, 4'b0110, 1};
`ifdef ALU_SEQ_ITER_EN
        vecs[8] = '{3'd0, 16'h8000, 16'h8000, 4'd2, 16'h8000, 4'b0010, 2};
`else
        vecs[8] = '{3'd0, 16'h8000, 16'h8000, 4'd2, 16'h0000, 4'b0101, 1};
`endif

        // Reset state
        #1;
        check("rst.cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst.flags", 32'(flags), 32'd0);
        check("rst.operand1", 32'(alu_operand1), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst.release_ready", 32'(cmd_ready), 32'd1);

        // Directed vectors; first one also exercises 5 cycles of backpressure
        for (int i = 0; i < 9; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cnt,
                    vecs[i].res, vecs[i].fl, vecs[i].lat, (i == 0) ? 5 : (i % 3), 1'b0);
            $display("vec%0d op=%0d a=%h b=%h cnt=%0d -> res=%h flags=%b", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, vecs[i].cnt, vecs[i].res, vecs[i].fl);
        end

        // Flag restore in IDLE wins over a simultaneous command
        flags_load = 1'b1; flags_load_val = 4'b0100;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 16'h0001; cmd_b = 16'h0001; cmd_count = 4'd1;
        #1;
        check("restore.cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        flags_load = 1'b0; cmd_valid = 1'b0;
        check("restore.flags", 32'(flags), 32'b0100);
        @(posedge clk); #1;
        check("restore.not_accepted", 32'(rsp_valid), 32'd0);
        check("restore.idle_ready", 32'(cmd_ready), 32'd1);
        model_flags = 4'b0100;
        $display("restore flags=0100 with command blocked");

        // Flag restore during EXEC/DONE ignored; AND keeps carry and bit3 from ccr
        run_cmd("exec_restore", 3'd3, 16'hffff, 16'h00ff, 4'd2, 16'h00ff, 4'b0100,
                eff_count(4'd2), 1, 1'b1);
        $display("exec_restore flags=%b", flags);

        // Reset in the second EXEC cycle discards the operation
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_a = 16'hffff; cmd_b = 16'hffff; cmd_count = 4'd4;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst.flags", 32'(flags), 32'd0);
        check("midrst.cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("midrst.release_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("midrst.no_rsp", 32'(rsp_valid), 32'd0);
        end
        model_flags = 4'b0000;
        $display("midrst discarded, flags=%b", flags);

        // Randomized commands against the iterate-the-ALU reference model
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(3) == 0) begin
                r_val = 4'($urandom);
                flags_load = 1'b1; flags_load_val = r_val;
                @(posedge clk); #1;
                flags_load = 1'b0;
                check("rand.restore", 32'(flags), 32'(r_val));
                model_flags = r_val;
            end
            r_op = 3'($urandom); r_a = W'($urandom); r_b = W'($urandom); r_cnt = C'($urandom);
            n = eff_count(r_cnt);
            m_acc = r_a; m_f = model_flags;
            for (int k = 0; k < n; k++) {m_f, m_acc} = alu_f(m_acc, r_b, r_op, m_f);
            run_cmd($sformatf("rand%0d", t), r_op, r_a, r_b, r_cnt, m_acc, m_f, n,
                    int'($urandom_range(3)), 1'($urandom));
            $display("rand%0d op=%0d a=%h b=%h cnt=%0d -> res=%h flags=%b", t, r_op, r_a, r_b,
                     r_cnt, m_acc, m_f);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
